// File: rtl/sum_range_method.sv
// Method responder "sum": returns the sum of i over [lo, hi), one term per cycle.
// Optional completed-call counter port sum_calls is enabled by defining SUM_RANGE_CALL_COUNT_EN.
module sum_range_method #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sum_req,
   output logic             sum_busy,
   input  logic [WIDTH-1:0] sum_lo,
   input  logic [WIDTH-1:0] sum_hi,
   output logic [WIDTH-1:0] sum_return
`ifdef SUM_RANGE_CALL_COUNT_EN
   ,
   output logic [31:0]      sum_calls
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      LOOP = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state_reg, state_next;

   logic              busy_reg,   busy_next;
   logic signed [WIDTH-1:0] lo_reg,  lo_next;
   logic signed [WIDTH-1:0] hi_reg,  hi_next;
   logic signed [WIDTH-1:0] acc_reg, acc_next;
   logic signed [WIDTH-1:0] idx_reg, idx_next;
   logic [WIDTH-1:0]  return_reg, return_next;
   logic              in_range;

   // Index stops at hi_reg, so it never wraps even when hi is the maximum positive value.
   assign in_range = (idx_reg < hi_reg);

   always_comb begin
      state_next  = state_reg;
      lo_next     = lo_reg;
      hi_next     = hi_reg;
      acc_next    = acc_reg;
      idx_next    = idx_reg;
      return_next = return_reg;
      case (state_reg)
         IDLE: begin
            if (sum_req) begin
               lo_next    = sum_lo;
               hi_next    = sum_hi;
               state_next = INIT;
            end
         end
         INIT: begin
            acc_next   = '0;
            idx_next   = lo_reg;
            state_next = LOOP;
         end
         LOOP: begin
            if (in_range) begin
               acc_next = acc_reg + idx_reg;
               idx_next = idx_reg + 1'b1;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            return_next = acc_reg;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Busy is registered from the next state so it tracks (state != IDLE) exactly.
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         busy_reg   <= 1'b0;
         lo_reg     <= '0;
         hi_reg     <= '0;
         acc_reg    <= '0;
         idx_reg    <= '0;
         return_reg <= '0;
      end else begin
         state_reg  <= state_next;
         busy_reg   <= busy_next;
         lo_reg     <= lo_next;
         hi_reg     <= hi_next;
         acc_reg    <= acc_next;
         idx_reg    <= idx_next;
         return_reg <= return_next;
      end
   end

   assign sum_busy   = busy_reg;
   assign sum_return = return_reg;

`ifdef SUM_RANGE_CALL_COUNT_EN
   logic [31:0] calls_reg, calls_next;

   always_comb begin
      calls_next = calls_reg;
      if (state_reg == DONE) begin
         calls_next = calls_reg + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         calls_reg <= '0;
      end else begin
         calls_reg <= calls_next;
      end
   end

   assign sum_calls = calls_reg;
`endif

endmodule

// File: tb/tb_sum_range_method.sv
// Directed bench for sum_range_method: 32-bit and 8-bit instances, latency, wrap, ignore-while-busy, reset abort.
module tb_sum_range_method;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        busy;
   logic [31:0] lo, hi, ret;
   logic        b_req;
   logic        b_busy;
   logic [7:0]  b_lo, b_hi, b_ret;
`ifdef SUM_RANGE_CALL_COUNT_EN
   logic [31:0] calls, b_calls;
`endif

   int errors = 0;
   int checks = 0;
   int cyc;
   int idle;

   always #5 clk = ~clk;

   sum_range_method #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .sum_req(req), .sum_busy(busy),
      .sum_lo(lo), .sum_hi(hi), .sum_return(ret)
`ifdef SUM_RANGE_CALL_COUNT_EN
      , .sum_calls(calls)
`endif
   );

   sum_range_method #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .sum_req(b_req), .sum_busy(b_busy),
      .sum_lo(b_lo), .sum_hi(b_hi), .sum_return(b_ret)
`ifdef SUM_RANGE_CALL_COUNT_EN
      , .sum_calls(b_calls)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Counts clock edges until busy drops, bounded.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run32(input string tag, input logic [31:0] l, input logic [31:0] h,
                        input int exp_cyc, input logic [31:0] exp_ret);
      int n;
      @(negedge clk);
      lo = l; hi = h; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
      wait_idle(n);
      check({tag, "_busy_cycles"}, n, exp_cyc);
      check({tag, "_return"}, ret, exp_ret);
      $display("call %s lo=%0d hi=%0d busy_cycles=%0d return=0x%08h", tag,
               $signed(l), $signed(h), n, ret);
   endtask

   task automatic run8(input string tag, input logic [7:0] l, input logic [7:0] h,
                       input int exp_cyc, input logic [7:0] exp_ret);
      int n;
      @(negedge clk);
      b_lo = l; b_hi = h; b_req = 1'b1;
      @(posedge clk); #1;
      b_req = 1'b0;
      n = 0;
      while (b_busy && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_busy_cycles"}, n, exp_cyc);
      check({tag, "_return"}, {24'd0, b_ret}, {24'd0, exp_ret});
      $display("call %s lo=%0d hi=%0d busy_cycles=%0d return=0x%02h", tag, l, h, n, b_ret);
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; lo = '0; hi = '0;
      b_req = 1'b0; b_lo = '0; b_hi = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_return", ret, 32'd0);
`ifdef SUM_RANGE_CALL_COUNT_EN
      check("reset_calls", calls, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", {31'd0, busy}, 32'd0);

      run32("sum_3_100", 32'd3, 32'd100, 100, 32'd4947);
      run32("empty_5_5", 32'd5, 32'd5, 3, 32'd0);
      run32("empty_7_2", 32'd7, 32'd2, 3, 32'd0);
      run32("neg_m4_2", 32'hFFFF_FFFC, 32'd2, 9, 32'hFFFF_FFF7);
      run32("hi_max", 32'h7FFF_FFFE, 32'h7FFF_FFFF, 4, 32'h7FFF_FFFE);

      // 100+101+102+103 = 406 -> 0x96; 120..126 = 861 -> 0x5D
      run8("w8_100_104", 8'd100, 8'd104, 7, 8'h96);
      run8("w8_120_127", 8'd120, 8'd127, 10, 8'h5D);

      // Request with different bounds while busy must be ignored.
      @(negedge clk);
      lo = 32'd0; hi = 32'd10; req = 1'b1;
      @(posedge clk); #1;
      cyc = 0;
      while (busy && cyc < 1000) begin
         if (cyc == 4) begin
            req = 1'b1; lo = 32'd1; hi = 32'd3;
         end else begin
            req = 1'b0; lo = 32'd0; hi = 32'd10;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("busy_ignore_cycles", cyc, 13);
      check("busy_ignore_return", ret, 32'd45);
      $display("call ignore_while_busy busy_cycles=%0d return=0x%08h", cyc, ret);

      // Held request: back-to-back calls separated by exactly one idle cycle.
      lo = 32'd2; hi = 32'd5; req = 1'b1;
      @(posedge clk); #1;
      check("hold_start", {31'd0, busy}, 32'd1);
      wait_idle(cyc);
      check("hold_first_cycles", cyc, 6);
      check("hold_first_return", ret, 32'd9);
      idle = 0;
      while (!busy && idle < 10) begin
         @(posedge clk); #1;
         idle++;
      end
      req = 1'b0;
      check("hold_idle_gap", idle, 1);
      wait_idle(cyc);
      check("hold_second_cycles", cyc, 6);
      check("hold_second_return", ret, 32'd9);
      $display("call hold_req idle_gap=%0d busy_cycles=%0d return=0x%08h", idle, cyc, ret);

      // Reset in the middle of LOOP aborts the call.
      @(negedge clk);
      lo = 32'd0; hi = 32'd50; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_return", ret, 32'd0);
`ifdef SUM_RANGE_CALL_COUNT_EN
      check("abort_calls", calls, 32'd0);
`endif
      $display("reset_abort busy=%0d return=0x%08h", busy, ret);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_stays_idle", {31'd0, busy}, 32'd0);

      run32("post_0_50", 32'd0, 32'd50, 53, 32'd1225);
      run32("post_10_12", 32'd10, 32'd12, 5, 32'd21);
`ifdef SUM_RANGE_CALL_COUNT_EN
      check("calls_after_two", calls, 32'd2);
      $display("sum_calls=%0d", calls);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
